// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA timing path.
package vga_timing_pkg;

    typedef logic [10:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    function automatic int raster_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = raster_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = raster_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle: pixel enable in, scan coordinates and sync/blank/frame strobes out.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic   pixelEn;
    coord_t pixelX;
    coord_t pixelY;
    logic   hSyncN;
    logic   vSyncN;
    logic   blankN;
    logic   startOfFrame;

    modport master (
        input  pixelEn,
        output pixelX, pixelY, hSyncN, vSyncN, blankN, startOfFrame
    );

    modport slave (
        output pixelEn,
        input  pixelX, pixelY, hSyncN, vSyncN, blankN, startOfFrame
    );

endinterface

// File: rtl/vga_sync_delay.sv
// STAGES-deep shift register for the {hSyncN, vSyncN, blankN} triple; resets to idle sync, blanked.
module vga_sync_delay #(
    parameter int STAGES = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [2:0] d,
    output logic [2:0] q
);

    localparam logic [2:0] IDLE = 3'b110;

    logic [STAGES-1:0][2:0] pipe;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pipe <= {STAGES{IDLE}};
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan counters plus registered sync/blank/start-of-frame.
// Optional VGA_SYNC_DELAY_EN delays hSyncN/vSyncN/blankN by SYNC_DELAY clk cycles.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SYNC_DELAY = 1
) (
    input  logic         clk,
    input  logic         resetN,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = raster_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEG = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t x_q, y_q, x_nxt, y_nxt;
    logic   hs_q, vs_q, bl_q, sof_q;

    always_comb begin
        x_nxt = x_q + coord_t'(1);
        y_nxt = y_q;
        if (x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
        end
    end

    // Decode is taken from the next coordinates so sync/blank land on the same edge as the counters.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            x_q   <= X_LAST;
            y_q   <= Y_LAST;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            bl_q  <= 1'b0;
            sof_q <= 1'b0;
        end else if (vga.pixelEn) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            hs_q  <= !(x_nxt >= HS_BEG && x_nxt < HS_END);
            vs_q  <= !(y_nxt >= VS_BEG && y_nxt < VS_END);
            bl_q  <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            sof_q <= (x_nxt == '0) && (y_nxt == '0);
        end else begin
            sof_q <= 1'b0;
        end
    end

    assign vga.pixelX       = x_q;
    assign vga.pixelY       = y_q;
    assign vga.startOfFrame = sof_q;

`ifdef VGA_SYNC_DELAY_EN
    logic [2:0] sync_dly;

    vga_sync_delay #(.STAGES(SYNC_DELAY)) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .d      ({hs_q, vs_q, bl_q}),
        .q      (sync_dly)
    );

    assign vga.hSyncN = sync_dly[2];
    assign vga.vSyncN = sync_dly[1];
    assign vga.blankN = sync_dly[0];
`else
    assign vga.hSyncN = hs_q;
    assign vga.vSyncN = vs_q;
    assign vga.blankN = bl_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the VGA path; sits directly upstream of the background and object draw stages.
- Produces the pixelX/pixelY scan coordinates consumed by every draw block, plus hSyncN/vSyncN/blankN for the VGA DAC output and a start-of-frame pulse for game logic.
- Default timing is 640x480@60 Hz, advanced by a pixel-clock enable so the system clock may be faster than the pixel clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 1, clk cycles of sync/blank delay (used only with VGA_SYNC_DELAY_EN); range 1..4

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
pixelEn  in  1  pixel-clock enable; raster advances one pixel per clk with pixelEn=1
pixelX  out  11  current horizontal count, 0..H_TOTAL-1
pixelY  out  11  current vertical count, 0..V_TOTAL-1
hSyncN  out  1  horizontal sync, active low
vSyncN  out  1  vertical sync, active low
blankN  out  1  1 = visible area, 0 = blanking
startOfFrame  out  1  one-clk pulse on entry to (0,0)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is resetN.
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Reset (resetN=0 at a clk edge):
  - pixelX=H_TOTAL-1 (799), pixelY=V_TOTAL-1 (524).
  - hSyncN=1, vSyncN=1, blankN=0, startOfFrame=0.
  - Reset overrides pixelEn. Reset mid-frame returns to this state on the same edge.
- Advance (clk edge with resetN=1, pixelEn=1):
  - pixelX increments.
  - At H_TOTAL-1, pixelX wraps to 0 and pixelY increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
  - With pixelEn=0, all counters and outputs hold, except startOfFrame, which drops to 0.
- All outputs are registered and mutually aligned: hSyncN/vSyncN/blankN always decode the pixelX/pixelY currently presented. Zero extra latency when VGA_SYNC_DELAY_EN is undefined.
- Decode:
  - hSyncN=0 iff H_VISIBLE+H_FP <= pixelX < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vSyncN=0 iff V_VISIBLE+V_FP <= pixelY < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blankN=1 iff pixelX < H_VISIBLE and pixelY < V_VISIBLE.
- startOfFrame:
  - 1 for exactly the single clk cycle after the advance into (0,0), including the first advance after reset.
  - Not repeated while pixelEn=0 holds the raster at (0,0).
- Width: all counters are 11-bit unsigned. Compare against the parameter-derived constants only; never compare against literal values.
- pixelEn toggling every cycle (50 MHz clk, 25 MHz pixel) gives a 2-clk dwell per pixel; decode must not glitch across a dwell.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - hSyncN, vSyncN and blankN pass through a SYNC_DELAY-stage clk-cycle shift register, matching the registered latency of the downstream draw/mux stages. pixelX/pixelY/startOfFrame are not delayed.
  - Delay stages reset to 1/1/0 (hSyncN/vSyncN/blankN).
- Undefined: no delay stages; outputs as described in Behaviour.

Decomposition:
- Package vga_timing_pkg:
  - Default timing constants (H_/V_ visible, porch and sync values), H_TOTAL/V_TOTAL derivation.
  - Coordinate type logic [10:0].
- One sub-module: vga_sync_delay, a parameterised SYNC_DELAY-stage 3-bit shift register with sync reset. Instantiated only under VGA_SYNC_DELAY_EN.

Test Plan:
- Reset then pixelEn=1 constant -> first edge gives (0,0), blankN=1, startOfFrame=1 for one clk; next edge gives (1,0), startOfFrame=0.
- Free-run one full frame -> exactly 420000 clk cycles between startOfFrame pulses; hSyncN low for 96 pixels at x=656..751 each line; vSyncN low only on lines 490..491.
- Line wrap -> (799,10) followed by (0,11); frame wrap (799,524) followed by (0,0) with startOfFrame=1.
- pixelEn alternating 1/0 -> each pixel held 2 clk; startOfFrame high 1 clk only; 840000 clk per frame.
- resetN=0 for one edge while at (300,200) -> (799,524), hSyncN=1, vSyncN=1, blankN=0 on that edge; raster restarts at (0,0) on the next enabled edge.
- VGA_SYNC_DELAY_EN, SYNC_DELAY=1 -> blankN rises one clk after pixelX=0 on line 0 is presented; hSyncN falls one clk after pixelX=656.
